// File: rtl/difftest_step_pkg.sv
// Shared types and width helpers for the difftest step batcher and the deferred-result stage.
// DEFAULT_STEP_WIDTH must track the deferred-result stage's stepwidth setting.
package difftest_step_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

  localparam int DEFAULT_STEP_WIDTH = 8;
  localparam int DEFAULT_MAX_BATCH  = 64;
  localparam int DEFAULT_TIMEOUT    = 1024;

  // Bits needed to hold 0..maxval inclusive.
  function automatic int cnt_width(input int maxval);
    return (maxval < 1) ? 1 : $clog2(maxval + 1);
  endfunction

  localparam int DEFAULT_ACC_W  = cnt_width(DEFAULT_MAX_BATCH);
  localparam int DEFAULT_IDLE_W = cnt_width(DEFAULT_TIMEOUT);

endpackage

// File: rtl/difftest_step_batcher_if.sv
// Bundle between the commit-event source / deferred checker and the step batcher.
// master = environment side, slave = batcher side.
interface difftest_step_batcher_if
  import difftest_step_pkg::*;
#(
  parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH
);
  logic                  in_valid;
  logic                  flush_req;
  logic [7:0]            simv_result;
  logic [STEP_WIDTH-1:0] step;
  logic                  halted;
  logic [63:0]           total_steps;

  modport master (
    output in_valid, flush_req, simv_result,
    input  step, halted, total_steps
  );

  modport slave (
    input  in_valid, flush_req, simv_result,
    output step, halted, total_steps
  );
endinterface

// File: rtl/difftest_idle_timer.sv
// Counts idle cycles of a non-empty batch; o_timeout_hit flags the cycle that must force a flush.
// Combinational hit output, counter updates on the next edge.
module difftest_idle_timer
  import difftest_step_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run_idle,
  input  logic i_in_valid,
  output logic o_timeout_hit
);
  localparam int IDLE_W = cnt_width(TIMEOUT);

  logic [IDLE_W-1:0] r_idle_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_idle_cnt <= '0;
    end else if (i_run_idle) begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end else begin
      r_idle_cnt <= '0;
    end
  end

  assign o_timeout_hit = (r_idle_cnt == IDLE_W'(TIMEOUT - 1)) && !i_in_valid;

endmodule

// File: rtl/difftest_step_batcher.sv
// Batches difftest commit events into one-cycle step pulses (full / flush / timeout), 1-cycle latency.
// Timeout flush only when CONFIG_DIFFTEST_STEP_TIMEOUT_EN is defined; halts for good on non-zero simv_result.
module difftest_step_batcher
  import difftest_step_pkg::*;
#(
  parameter int STEP_WIDTH = DEFAULT_STEP_WIDTH,
  parameter int MAX_BATCH  = DEFAULT_MAX_BATCH,
  parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
  input  logic                     clock,
  input  logic                     reset,
  difftest_step_batcher_if.slave   bus
);
  localparam int ACC_W = cnt_width(MAX_BATCH);

  if (MAX_BATCH < 1 || (MAX_BATCH >> STEP_WIDTH) != 0) begin : g_bad_max_batch
    $error("MAX_BATCH must be in 1..2^STEP_WIDTH-1");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be >= 1");
  end

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ACC_W-1:0]      r_acc;
  logic [ACC_W-1:0]      w_acc_nxt;
  logic [STEP_WIDTH-1:0] r_step;
  logic [STEP_WIDTH-1:0] w_step_nxt;
  logic [63:0]           r_total;
  logic [63:0]           w_total_nxt;
  logic [ACC_W-1:0]      w_sum;
  logic                  w_take_halt;
  logic                  w_fire;
  logic                  w_timeout_hit;

  assign w_sum       = r_acc + ACC_W'(bus.in_valid);
  assign w_take_halt = (r_state == ST_RUN) && (bus.simv_result != 8'd0);
  assign w_fire      = (w_sum == ACC_W'(MAX_BATCH)) ||
                       ((w_sum != '0) && (bus.flush_req || w_timeout_hit));

`ifdef CONFIG_DIFFTEST_STEP_TIMEOUT_EN
  logic w_run_idle;
  // Keep counting only while a batch is open, nothing arrived and nothing closed it.
  assign w_run_idle = (r_state == ST_RUN) && !w_take_halt && !w_fire &&
                      (w_sum != '0) && !bus.in_valid;

  difftest_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clock         (clock),
    .reset         (reset),
    .i_run_idle    (w_run_idle),
    .i_in_valid    (bus.in_valid),
    .o_timeout_hit (w_timeout_hit)
  );
`else
  assign w_timeout_hit = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_take_halt) begin
      w_state_nxt = ST_HALT;
    end
  end

  // Halt wins over fire: the pending batch is dropped without a pulse.
  always_comb begin
    w_step_nxt  = '0;
    w_acc_nxt   = '0;
    w_total_nxt = r_total;
    if (r_state == ST_RUN && !w_take_halt) begin
      if (w_fire) begin
        w_step_nxt  = STEP_WIDTH'(w_sum);
        w_total_nxt = r_total + 64'(w_sum);
      end else begin
        w_acc_nxt = w_sum;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc   <= '0;
      r_step  <= '0;
      r_total <= '0;
    end else begin
      r_acc   <= w_acc_nxt;
      r_step  <= w_step_nxt;
      r_total <= w_total_nxt;
    end
  end

  assign bus.step        = r_step;
  assign bus.halted      = (r_state == ST_HALT);
  assign bus.total_steps = r_total;

endmodule

// File: tb/tb_difftest_step_batcher.sv
// Directed scenarios plus randomized traffic, compared every cycle against a timestamp-based batch model.
module tb_difftest_step_batcher;
  localparam int STEP_WIDTH = 8;
  localparam int MAX_BATCH  = 4;
  localparam int TIMEOUT    = 5;

  logic clock = 1'b0;
  logic reset = 1'b1;

  difftest_step_batcher_if #(.STEP_WIDTH(STEP_WIDTH)) bus ();

  difftest_step_batcher #(
    .STEP_WIDTH (STEP_WIDTH),
    .MAX_BATCH  (MAX_BATCH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending count plus the cycle number of the latest event.
  int          m_cyc     = 0;
  int          m_last_ev = -100000;
  int          m_pend    = 0;
  bit          m_halt    = 1'b0;
  logic [63:0] m_step    = '0;
  logic [63:0] m_total   = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, m_cyc, got, exp);
    end
  endtask

  task automatic model_step(input bit iv, input bit fr, input logic [7:0] sr, input bit rs);
    int sum;
    bit to;
    m_cyc++;
    if (rs) begin
      m_pend = 0; m_halt = 1'b0; m_step = '0; m_total = '0;
    end else if (m_halt) begin
      m_step = '0;
    end else if (sr != 8'd0) begin
      m_halt = 1'b1; m_pend = 0; m_step = '0;
    end else begin
      sum = m_pend + int'(iv);
      to  = 1'b0;
`ifdef CONFIG_DIFFTEST_STEP_TIMEOUT_EN
      to = !iv && (sum > 0) && (m_cyc - m_last_ev == TIMEOUT);
`endif
      if (iv) m_last_ev = m_cyc;
      if (sum == MAX_BATCH || (sum > 0 && (fr || to))) begin
        m_step  = 64'(sum);
        m_total = m_total + 64'(sum);
        m_pend  = 0;
      end else begin
        m_step = '0;
        m_pend = sum;
      end
    end
  endtask

  task automatic tick(input bit iv, input bit fr, input logic [7:0] sr, input bit rs);
    bus.in_valid    = iv;
    bus.flush_req   = fr;
    bus.simv_result = sr;
    reset           = rs;
    @(posedge clock);
    model_step(iv, fr, sr, rs);
    #1;
    check("step", 64'(bus.step), m_step);
    check("halted", 64'(bus.halted), 64'(m_halt));
    check("total_steps", bus.total_steps, m_total);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", m_cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] snap;
    int          p_iv;
    bit          iv;
    bit          fr;
    bit          rs;
    logic [7:0]  sr;

    bus.in_valid    = 1'b0;
    bus.flush_req   = 1'b0;
    bus.simv_result = 8'd0;

    tick(0, 0, 8'd0, 1);
    tick(1, 1, 8'd0, 1);
    check("reset_step", 64'(bus.step), 64'd0);
    check("reset_total", bus.total_steps, 64'd0);

    // Burst: full batches at the 4th and 8th event, 2 left pending.
    for (int i = 1; i <= 10; i++) begin
      tick(1, 0, 8'd0, 0);
      if (i == 4 || i == 8) check("burst_step", 64'(bus.step), 64'd4);
    end
    check("burst_total", bus.total_steps, 64'd8);

    // Flush: 3 events + flush with an event -> 4; empty flush -> nothing.
    tick(0, 0, 8'd0, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 8'd0, 0);
    tick(1, 1, 8'd0, 0);
    check("flush_step", 64'(bus.step), 64'd4);
    tick(0, 1, 8'd0, 0);
    check("flush_empty_step", 64'(bus.step), 64'd0);
    check("flush_total", bus.total_steps, 64'd4);

    // Timeout: 2 events, then idle.
    tick(0, 0, 8'd0, 1);
    tick(1, 0, 8'd0, 0);
    tick(1, 0, 8'd0, 0);
    for (int i = 1; i <= 100; i++) begin
      tick(0, 0, 8'd0, 0);
`ifdef CONFIG_DIFFTEST_STEP_TIMEOUT_EN
      if (i == TIMEOUT) check("timeout_step", 64'(bus.step), 64'd2);
`endif
    end
`ifdef CONFIG_DIFFTEST_STEP_TIMEOUT_EN
    check("timeout_total", bus.total_steps, 64'd2);
`else
    check("no_timeout_total", bus.total_steps, 64'd0);
`endif

    // Halt with 3 pending; nothing moves afterwards.
    tick(0, 0, 8'd0, 1);
    for (int i = 0; i < 4; i++) tick(1, 0, 8'd0, 0);
    for (int i = 0; i < 3; i++) tick(1, 0, 8'd0, 0);
    snap = bus.total_steps;
    tick(0, 0, 8'h01, 0);
    check("halt_halted", 64'(bus.halted), 64'd1);
    for (int i = 0; i < 20; i++) tick(1'($urandom), 1'($urandom), 8'($urandom), 0);
    check("halt_total_frozen", bus.total_steps, snap);

    // Reset mid-batch discards the pending events.
    tick(0, 0, 8'd0, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 8'd0, 0);
    tick(0, 0, 8'd0, 1);
    for (int i = 1; i <= 4; i++) begin
      tick(1, 0, 8'd0, 0);
      if (i == 3) check("rst_no_carry", 64'(bus.step), 64'd0);
    end
    check("rst_batch_step", 64'(bus.step), 64'd4);

    // Batch completes on the same cycle the checker reports failure.
    tick(0, 0, 8'd0, 1);
    for (int i = 0; i < 3; i++) tick(1, 0, 8'd0, 0);
    tick(1, 0, 8'h80, 0);
    check("simul_step", 64'(bus.step), 64'd0);
    check("simul_halted", 64'(bus.halted), 64'd1);

    // Random traffic in phases of differing event density.
    tick(0, 0, 8'd0, 1);
    for (int ph = 0; ph < 6; ph++) begin
      p_iv = (ph % 3 == 0) ? 75 : ((ph % 3 == 1) ? 35 : 12);
      for (int i = 0; i < 500; i++) begin
        iv = ($urandom_range(0, 99) < p_iv);
        fr = ($urandom_range(0, 99) < 6);
        sr = ($urandom_range(0, 399) == 0) ? 8'($urandom_range(1, 255)) : 8'd0;
        rs = m_halt ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 299) == 0);
        tick(iv, fr, sr, rs);
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
